// File: rtl/stack_down_pkt_router_pkg.sv
// rtl/stack_down_pkt_router_pkg.sv - flit/header encodings and FSM states for the downstream packet router
package stack_down_pkt_router_pkg;

  localparam logic [1:0] CNTL_MOP     = 2'b00;
  localparam logic [1:0] CNTL_SOP     = 2'b01;
  localparam logic [1:0] CNTL_EOP     = 2'b10;
  localparam logic [1:0] CNTL_SOP_EOP = 2'b11;

  localparam logic [1:0] TYPE_CTRL = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int LANE_LO = 25;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_WAIT,
    ST_CTRL_OUT,
    ST_DATA_FWD,
    ST_DROP
  } state_e;

  function automatic logic cntl_is_sop(input logic [1:0] c);
    return (c == CNTL_SOP) || (c == CNTL_SOP_EOP);
  endfunction

  function automatic logic cntl_is_eop(input logic [1:0] c);
    return (c == CNTL_EOP) || (c == CNTL_SOP_EOP);
  endfunction

endpackage

// File: rtl/stack_down_fifo.sv
// rtl/stack_down_fifo.sv - first-word-fall-through input FIFO with a registered not-full flag
module stack_down_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             ready_q;
  logic             push_ok, pop_ok;

  // ready_q only ever reflects the committed count, so a push never rides on a same-cycle pop
  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/stack_down_pkt_router.sv
// rtl/stack_down_pkt_router.sv - routes downstream stack-bus packets to control writes or streaming-op lanes
module stack_down_pkt_router
  import stack_down_pkt_router_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_LANES  = 32,
  parameter int LANE_W     = $clog2(NUM_LANES),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              sys__pe__down_valid,
  input  logic [1:0]        sys__pe__down_cntl,
  input  logic [DATA_W-1:0] sys__pe__down_data,
  output logic              pe__sys__down_ready,
  output logic              si__stOp__valid,
  output logic [LANE_W-1:0] si__stOp__lane,
  output logic [DATA_W-1:0] si__stOp__data,
  output logic              si__stOp__eop,
  input  logic              stOp__si__ready,
  output logic              si__cntl__wr_valid,
  output logic [15:0]       si__cntl__wr_addr,
  output logic [DATA_W-1:0] si__cntl__wr_data,
  input  logic              cntl__si__wr_ready,
  output logic [7:0]        si__err_count
);

  logic [DATA_W+1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [1:0]        head_cntl;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        hdr_type;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [15:0]       addr_q, addr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              st_valid_q, st_valid_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic              st_eop_q, st_eop_d;
  logic [7:0]        err_q;
  logic              err_inc;

  stack_down_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_poweron),
    .push_i  (sys__pe__down_valid),
    .data_i  ({sys__pe__down_cntl, sys__pe__down_data}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .ready_o (pe__sys__down_ready)
  );

  assign head_cntl = fifo_dout[DATA_W+1:DATA_W];
  assign head_data = fifo_dout[DATA_W-1:0];
  assign hdr_type  = head_data[TYPE_HI:TYPE_LO];

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    err_inc    = 1'b0;
    lane_d     = lane_q;
    addr_d     = addr_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    st_valid_d = st_valid_q;
    st_data_d  = st_data_q;
    st_eop_d   = st_eop_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!cntl_is_sop(head_cntl) || (head_cntl == CNTL_SOP_EOP)) begin
            err_inc = 1'b1;
          end else begin
            case (hdr_type)
              TYPE_CTRL: begin
                addr_d  = head_data[ADDR_HI:ADDR_LO];
                state_d = ST_CTRL_WAIT;
              end
              TYPE_DATA: begin
                lane_d  = head_data[LANE_LO +: LANE_W];
                state_d = ST_DATA_FWD;
              end
              default: begin
                err_inc = 1'b1;
                state_d = ST_DROP;
              end
            endcase
          end
        end
      end

      ST_CTRL_WAIT: begin
        if (!fifo_empty) begin
          if (head_cntl == CNTL_EOP) begin
            fifo_pop   = 1'b1;
            wr_valid_d = 1'b1;
            wr_data_d  = head_data;
            state_d    = ST_CTRL_OUT;
          end else if (head_cntl == CNTL_MOP) begin
            fifo_pop = 1'b1;
            err_inc  = 1'b1;
            state_d  = ST_DROP;
          end else begin
            // a new header cuts the write short; leave it for IDLE to parse
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_CTRL_OUT: begin
        if (cntl__si__wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_DATA_FWD: begin
        if (st_valid_q && st_eop_q) begin
          if (stOp__si__ready) begin
            st_valid_d = 1'b0;
            st_eop_d   = 1'b0;
            state_d    = ST_IDLE;
          end
        end else if (!st_valid_q || stOp__si__ready) begin
          st_valid_d = 1'b0;
          if (!fifo_empty) begin
            if (cntl_is_sop(head_cntl)) begin
              err_inc = 1'b1;
              state_d = ST_IDLE;
            end else begin
              fifo_pop   = 1'b1;
              st_valid_d = 1'b1;
              st_data_d  = head_data;
              st_eop_d   = cntl_is_eop(head_cntl);
            end
          end
        end
      end

      ST_DROP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (cntl_is_eop(head_cntl)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
      st_eop_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      st_valid_q <= st_valid_d;
      st_data_q  <= st_data_d;
      st_eop_q   <= st_eop_d;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign si__stOp__valid    = st_valid_q;
  assign si__stOp__lane     = lane_q;
  assign si__stOp__data     = st_data_q;
  assign si__stOp__eop      = st_eop_q;
  assign si__cntl__wr_valid = wr_valid_q;
  assign si__cntl__wr_addr  = addr_q;
  assign si__cntl__wr_data  = wr_data_q;
  assign si__err_count      = err_q;

endmodule

// File: tb/tb_stack_down_pkt_router.sv
// tb/tb_stack_down_pkt_router.sv - directed self-checking bench for stack_down_pkt_router
module tb_stack_down_pkt_router;

  localparam logic [1:0] SOP = 2'b01;
  localparam logic [1:0] MOP = 2'b00;
  localparam logic [1:0] EOP = 2'b10;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        sys__pe__down_valid;
  logic [1:0]  sys__pe__down_cntl;
  logic [31:0] sys__pe__down_data;
  logic        pe__sys__down_ready;
  logic        si__stOp__valid;
  logic [4:0]  si__stOp__lane;
  logic [31:0] si__stOp__data;
  logic        si__stOp__eop;
  logic        stOp__si__ready;
  logic        si__cntl__wr_valid;
  logic [15:0] si__cntl__wr_addr;
  logic [31:0] si__cntl__wr_data;
  logic        cntl__si__wr_ready;
  logic [7:0]  si__err_count;

  logic st_rdy;
  logic tog_en;
  logic tog_q = 1'b0;
  assign stOp__si__ready = tog_en ? tog_q : st_rdy;

  stack_down_pkt_router dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .sys__pe__down_valid (sys__pe__down_valid),
    .sys__pe__down_cntl  (sys__pe__down_cntl),
    .sys__pe__down_data  (sys__pe__down_data),
    .pe__sys__down_ready (pe__sys__down_ready),
    .si__stOp__valid     (si__stOp__valid),
    .si__stOp__lane      (si__stOp__lane),
    .si__stOp__data      (si__stOp__data),
    .si__stOp__eop       (si__stOp__eop),
    .stOp__si__ready     (stOp__si__ready),
    .si__cntl__wr_valid  (si__cntl__wr_valid),
    .si__cntl__wr_addr   (si__cntl__wr_addr),
    .si__cntl__wr_data   (si__cntl__wr_data),
    .cntl__si__wr_ready  (cntl__si__wr_ready),
    .si__err_count       (si__err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tog_q = ~tog_q;
  end

  logic [31:0] cap_data [0:511];
  logic [4:0]  cap_lane [0:511];
  logic        cap_eop  [0:511];
  int          cap_cyc  [0:511];
  int          cap_n = 0;
  logic [15:0] ctl_addr [0:15];
  logic [31:0] ctl_data [0:15];
  int          ctl_n = 0;
  int          rdy_low_n = 0;

  // handshakes are sampled mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    if (reset_poweron) begin
      if (si__stOp__valid && stOp__si__ready && cap_n < 512) begin
        cap_data[cap_n] = si__stOp__data;
        cap_lane[cap_n] = si__stOp__lane;
        cap_eop[cap_n]  = si__stOp__eop;
        cap_cyc[cap_n]  = cyc;
        cap_n = cap_n + 1;
      end
      if (si__cntl__wr_valid && cntl__si__wr_ready && ctl_n < 16) begin
        ctl_addr[ctl_n] = si__cntl__wr_addr;
        ctl_data[ctl_n] = si__cntl__wr_data;
        ctl_n = ctl_n + 1;
      end
      if (!pe__sys__down_ready) rdy_low_n = rdy_low_n + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] d, output int at);
    int   g;
    logic acc;
    g   = 0;
    acc = 1'b0;
    sys__pe__down_valid = 1'b1;
    sys__pe__down_cntl  = c;
    sys__pe__down_data  = d;
    while (!acc && g < 100) begin
      acc = pe__sys__down_ready;
      tick();
      g++;
    end
    sys__pe__down_valid = 1'b0;
    at = cyc;
    if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_caps(input int n);
    int g;
    g = 0;
    while (cap_n < n && g < 200) begin
      tick();
      g++;
    end
    if (cap_n < n) check("cap_timeout", cap_n, n);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [4:0] lane, input logic eop);
    check($sformatf("%s_data%0d", tag, idx), cap_data[idx], d);
    check($sformatf("%s_lane%0d", tag, idx), {27'd0, cap_lane[idx]}, {27'd0, lane});
    check($sformatf("%s_eop%0d", tag, idx), {31'd0, cap_eop[idx]}, {31'd0, eop});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int at;
  int hc;
  int base;
  int low0;
  int g;

  initial begin
    reset_poweron       = 1'b0;
    sys__pe__down_valid = 1'b0;
    sys__pe__down_cntl  = 2'b00;
    sys__pe__down_data  = 32'd0;
    st_rdy              = 1'b1;
    tog_en              = 1'b0;
    cntl__si__wr_ready  = 1'b0;
    repeat (3) tick();

    check("rst_ready", {31'd0, pe__sys__down_ready}, 32'd0);
    check("rst_st_valid", {31'd0, si__stOp__valid}, 32'd0);
    check("rst_wr_valid", {31'd0, si__cntl__wr_valid}, 32'd0);
    check("rst_err", {24'd0, si__err_count}, 32'd0);
    reset_poweron = 1'b1;
    tick();
    check("ready_after_release", {31'd0, pe__sys__down_ready}, 32'd1);

    // control write held under backpressure
    send(SOP, 32'h0000_0040, at);
    send(EOP, 32'hDEAD_BEEF, at);
    g = 0;
    while (!si__cntl__wr_valid && g < 20) begin tick(); g++; end
    check("ctrl_valid", {31'd0, si__cntl__wr_valid}, 32'd1);
    check("ctrl_addr", {16'd0, si__cntl__wr_addr}, 32'h0040);
    check("ctrl_data", si__cntl__wr_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ctrl_hold_valid", {31'd0, si__cntl__wr_valid}, 32'd1);
      check("ctrl_hold_addr", {16'd0, si__cntl__wr_addr}, 32'h0040);
      check("ctrl_hold_data", si__cntl__wr_data, 32'hDEAD_BEEF);
    end
    cntl__si__wr_ready = 1'b1;
    tick();
    cntl__si__wr_ready = 1'b0;
    check("ctrl_released", {31'd0, si__cntl__wr_valid}, 32'd0);
    check("ctrl_xfers", ctl_n, 32'd1);
    check("ctrl_xfer_addr", {16'd0, ctl_addr[0]}, 32'h0040);
    check("ctrl_xfer_data", ctl_data[0], 32'hDEAD_BEEF);
    check("ctrl_err", {24'd0, si__err_count}, 32'd0);

    // data packet, lane 7, ready held high
    base = cap_n;
    send(SOP, 32'h4E00_0000, hc);
    for (int i = 1; i <= 4; i++) send((i == 4) ? EOP : MOP, i, at);
    wait_caps(base + 4);
    check("data_latency", cap_cyc[base], hc + 2);
    for (int i = 0; i < 4; i++) begin
      check_word("data", base + i, i + 1, 5'd7, (i == 3));
      if (i > 0) check($sformatf("data_consec%0d", i), cap_cyc[base + i], cap_cyc[base + i - 1] + 1);
    end

    // lane ready toggling every cycle on an 8-word packet to lane 3
    base   = cap_n;
    low0   = rdy_low_n;
    tog_en = 1'b1;
    send(SOP, 32'h4600_0000, at);
    for (int i = 0; i < 8; i++) send((i == 7) ? EOP : MOP, 32'h100 + i, at);
    wait_caps(base + 8);
    tog_en = 1'b0;
    repeat (4) tick();
    check("bp_ready_dropped", {31'd0, rdy_low_n > low0}, 32'd1);
    check("bp_count", cap_n, base + 8);
    for (int i = 0; i < 8; i++) check_word("bp", base + i, 32'h100 + i, 5'd3, (i == 7));

    // reserved type dropped with its payload
    base = cap_n;
    send(SOP, 32'h8000_0000, at);
    send(MOP, 32'h0000_00AA, at);
    send(EOP, 32'h0000_00BB, at);
    repeat (8) tick();
    check("rsvd_err", {24'd0, si__err_count}, 32'd1);
    check("rsvd_no_data", cap_n, base);
    check("rsvd_no_ctrl", ctl_n, 32'd1);

    send(MOP, 32'h0000_0055, at);
    repeat (8) tick();
    check("lone_mop_err", {24'd0, si__err_count}, 32'd2);

    // SOP in the middle of a lane-5 packet restarts on lane 9
    base = cap_n;
    send(SOP, 32'h4A00_0000, at);
    send(MOP, 32'h11, at);
    send(MOP, 32'h22, at);
    send(SOP, 32'h5200_0000, at);
    send(MOP, 32'h33, at);
    send(EOP, 32'h44, at);
    wait_caps(base + 4);
    repeat (4) tick();
    check("midsop_err", {24'd0, si__err_count}, 32'd3);
    check("midsop_count", cap_n, base + 4);
    check_word("midsop", base + 0, 32'h11, 5'd5, 1'b0);
    check_word("midsop", base + 1, 32'h22, 5'd5, 1'b0);
    check_word("midsop", base + 2, 32'h33, 5'd9, 1'b0);
    check_word("midsop", base + 3, 32'h44, 5'd9, 1'b1);

    // 300 bad flits: reaches 255 exactly, then stays there
    for (int i = 0; i < 252; i++) send(MOP, i, at);
    repeat (4) tick();
    check("sat_reach", {24'd0, si__err_count}, 32'd255);
    for (int i = 0; i < 48; i++) send(MOP, i, at);
    repeat (4) tick();
    check("sat_hold", {24'd0, si__err_count}, 32'd255);

    // reset after 2 of 5 words on lane 2
    base = cap_n;
    send(SOP, 32'h4400_0000, at);
    send(MOP, 32'h201, at);
    send(MOP, 32'h202, at);
    wait_caps(base + 2);
    check_word("prerst", base + 1, 32'h202, 5'd2, 1'b0);
    reset_poweron = 1'b0;
    #1;
    check("mrst_ready", {31'd0, pe__sys__down_ready}, 32'd0);
    check("mrst_st_valid", {31'd0, si__stOp__valid}, 32'd0);
    check("mrst_lane", {27'd0, si__stOp__lane}, 32'd0);
    check("mrst_data", si__stOp__data, 32'd0);
    check("mrst_eop", {31'd0, si__stOp__eop}, 32'd0);
    check("mrst_wr_valid", {31'd0, si__cntl__wr_valid}, 32'd0);
    check("mrst_wr_addr", {16'd0, si__cntl__wr_addr}, 32'd0);
    check("mrst_wr_data", si__cntl__wr_data, 32'd0);
    check("mrst_err", {24'd0, si__err_count}, 32'd0);
    repeat (2) tick();
    reset_poweron = 1'b1;
    tick();
    base = cap_n;
    send(SOP, 32'h4800_0000, at);
    send(MOP, 32'h301, at);
    send(MOP, 32'h302, at);
    send(EOP, 32'h303, at);
    wait_caps(base + 3);
    repeat (4) tick();
    check("post_count", cap_n, base + 3);
    check_word("post", base + 0, 32'h301, 5'd4, 1'b0);
    check_word("post", base + 1, 32'h302, 5'd4, 1'b0);
    check_word("post", base + 2, 32'h303, 5'd4, 1'b1);
    check("post_err", {24'd0, si__err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_down_pkt_router.md
Name: stack_down_pkt_router

Overview:
- Sits directly downstream of the PE stack-bus downstream port, between the stack bus and the streaming-op lanes / local controller.
- Accepts one flit per cycle from the downstream stack bus into a small input FIFO, parses the packet header, and routes the packet:
  - control packets become single register-write transactions to the local controller;
  - data packets go to one streaming-op lane;
  - reserved or malformed packets are dropped and counted.

Parameters:
- DATA_W, 32: flit / payload width.
- NUM_LANES, 32: streaming-op lanes.
- LANE_W, 5: lane-id width; must satisfy 2^LANE_W >= NUM_LANES.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock.
- reset_poweron  in  1  asynchronous, active-low reset.
- sys__pe__down_valid  in  1  flit valid.
- sys__pe__down_cntl  in  2  01=SOP, 00=MOP, 10=EOP, 11=SOP+EOP.
- sys__pe__down_data  in  DATA_W  flit.
- pe__sys__down_ready  out  1  high when the FIFO is not full.
- si__stOp__valid  out  1  lane payload valid.
- si__stOp__lane  out  LANE_W  destination lane.
- si__stOp__data  out  DATA_W  payload.
- si__stOp__eop  out  1  last payload word.
- stOp__si__ready  in  1  selected lane ready.
- si__cntl__wr_valid  out  1  control write valid.
- si__cntl__wr_addr  out  16  control address.
- si__cntl__wr_data  out  DATA_W  control write data.
- cntl__si__wr_ready  in  1  controller accepts.
- si__err_count  out  8  saturating dropped-packet counter.

Behaviour:
- Reset (async, reset_poweron=0):
  - FIFO empty; FSM to IDLE.
  - All valid outputs 0; lane, data, addr and eop outputs 0.
  - Error counter 0.
  - pe__sys__down_ready=0 while reset is asserted, 1 on the first clk edge after release.
- Input:
  - A flit is written when valid && ready. Ready = !full; it is registered and does not depend on the same-cycle pop.
  - Simultaneous push and pop when full is not allowed; the push waits.
  - FIFO read is first-word fall-through to the FSM.
- Header flit (SOP):
  - [31:30] type: 00=CTRL, 01=DATA, 1x=reserved.
  - [29:25] lane (DATA only).
  - [15:0] addr (CTRL only).
  - The header is consumed and not forwarded.
- FSM states and transitions:
  - IDLE: pop the head flit.
    - Not SOP → increment error count, stay in IDLE.
    - SOP+EOP → header-only packet, counted as an error (CTRL needs data, DATA with no payload); stay in IDLE.
    - SOP, type CTRL → CTRL_WAIT; latch addr.
    - SOP, type DATA → DATA_FWD; latch lane.
    - SOP, reserved type → DROP; increment error count.
  - CTRL_WAIT: take the next flit as wdata.
    - Must be EOP. If it is MOP, drop the remainder and increment error count.
    - Present wr_valid/addr/data registered one cycle after the pop.
    - Hold all three stable until cntl__si__wr_ready, then return to IDLE.
  - DATA_FWD: each popped flit drives si__stOp__valid/data/lane on registered outputs; eop is set when the flit is EOP.
    - Pop only when the output register is empty or being accepted this cycle (valid && ready). This sustains one word per cycle.
    - Last word accepted → IDLE.
    - An SOP seen mid-packet terminates the current packet and increments error count. That flit is then reprocessed as a header in IDLE; it is not consumed in DATA_FWD.
  - DROP: pop flits until EOP, then go to IDLE.
- Latency: header pop to first payload valid is 2 cycles when the FIFO holds data and the lane is ready.
- si__err_count saturates at 255 and never wraps.
- Outputs are held while their ready input is low.
- Reset asserted mid-packet: the packet is discarded and no partial transaction is emitted.

Decomposition:
- Shared package/header (stack_down_pkt.vh):
  - cntl encodings: SOP/MOP/EOP/SOP_EOP.
  - type encodings: CTRL/DATA.
  - header field ranges: TYPE, LANE, ADDR.
  - FSM state encodings.
- One natural sub-module: stack_down_fifo, a parameterized first-word-fall-through FIFO with full/empty, async active-low reset.

Test Plan:
- CTRL packet: SOP hdr 0x0000_0040 then EOP 0xDEAD_BEEF → wr_valid with addr=0x0040, data=0xDEADBEEF. Hold 3 cycles with ready=0, then 1 transfer. Error count 0.
- DATA packet: hdr lane=7 (0x4E00_0000) + 4 words (1,2,3,4) with ready=1 → lane=7, data 1..4 on 4 consecutive cycles, eop only on 4.
- Backpressure: stOp__si__ready toggles every cycle on an 8-word DATA packet → FIFO fills, pe__sys__down_ready drops to 0, no word lost or duplicated, order preserved.
- Errors:
  - reserved type 0x8000_0000 + 2 words → dropped, error count 1;
  - lone MOP in IDLE → error count 2;
  - SOP mid-DATA → packet terminated, error count 3, new packet routed correctly.
- Saturation: 300 bad flits → si__err_count=255.
- Reset mid-DATA after 2 of 5 words → all outputs 0 immediately, and the next full packet routes cleanly.
